// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, writeback bypass,
// and a per-register pending scoreboard that raises a decode stall on RAW hazards.
module regfile_sb #(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx,
    input  logic                     rs1_en,
    output logic [XLEN-1:0]          rs1_rdata,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx,
    input  logic                     rs2_en,
    output logic [XLEN-1:0]          rs2_rdata,
    input  logic                     iss_valid,
    input  logic [REG_IDX_WIDTH-1:0] iss_rd_idx,
    input  logic                     iss_rd_en,
    input  logic                     wb_en,
    input  logic [REG_IDX_WIDTH-1:0] wb_idx,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     flush,
    output logic                     hazard,
    output logic [31:0]              pending
);
    localparam int NREGS = 1 << REG_IDX_WIDTH;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             iss_take;

    // A live writeback to the same index forwards its data, so it never counts as busy.
    function automatic logic [XLEN-1:0] port_data(input logic en,
                                                  input logic [REG_IDX_WIDTH-1:0] idx,
                                                  input logic [XLEN-1:0] stored);
        if (!en || idx == '0)
            return '0;
        else if (wb_en && wb_idx == idx)
            return wb_data;
        else
            return stored;
    endfunction

    function automatic logic port_busy(input logic en,
                                       input logic [REG_IDX_WIDTH-1:0] idx,
                                       input logic busy);
        return en && (idx != '0) && busy && !(wb_en && wb_idx == idx);
    endfunction

    assign rs1_rdata = port_data(rs1_en, rs1_idx, regs_q[rs1_idx]);
    assign rs2_rdata = port_data(rs2_en, rs2_idx, regs_q[rs2_idx]);
    assign rs1_busy  = port_busy(rs1_en, rs1_idx, pending_q[rs1_idx]);
    assign rs2_busy  = port_busy(rs2_en, rs2_idx, pending_q[rs2_idx]);
    assign hazard    = rs1_busy | rs2_busy;
    assign pending   = 32'(pending_q);

    // Issue handshake: iss_valid is accepted only in a cycle with hazard=0; while
    // hazard=1 decode holds the instruction and nothing is recorded for it.
    assign iss_take = iss_valid && iss_rd_en && (iss_rd_idx != '0) && !hazard;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_idx != '0)
            regs_d[wb_idx] = wb_data;
        regs_d[0] = '0;
    end

    // Set beats clear (newer producer wins); flush beats both.
    always_comb begin
        pending_d = pending_q;
        if (wb_en)
            pending_d[wb_idx] = 1'b0;
        if (iss_take)
            pending_d[iss_rd_idx] = 1'b1;
        if (flush)
            pending_d = '0;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end
endmodule
